// File: rtl/equiv_sweep_checker.sv
// Exhaustive equivalence sweep: drives every N-bit vector into two implementations,
// holds each one SETTLE cycles, and counts / captures disagreements between y_a and y_b.
module equiv_sweep_checker #(
    parameter int N      = 3,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [N-1:0] vec_out,
    input  logic         y_a,
    input  logic         y_b,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   mismatch_cnt,
    output logic         first_fail_valid,
    output logic [N-1:0] first_fail_vec
);

    if (SETTLE < 1) begin : g_bad_settle
        $error("equiv_sweep_checker: SETTLE must be >= 1");
    end
    if (N < 1 || N > 16) begin : g_bad_width
        $error("equiv_sweep_checker: N must be in 1..16");
    end

    localparam int              WCNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(SETTLE - 1);
    localparam logic [N-1:0]    VEC_LAST  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [N-1:0]        vec_q, vec_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [N:0]          cnt_q, cnt_d;
    logic                ffv_q, ffv_d;
    logic [N-1:0]        ffvec_q, ffvec_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case leaves one unassigned (no latches).
        state_d = state_q;
        vec_d   = vec_q;
        wcnt_d  = wcnt_q;
        cnt_d   = cnt_q;
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = HOLD;
                    vec_d   = '0;
                    wcnt_d  = '0;
                    cnt_d   = '0;
                    ffv_d   = 1'b0;
                    ffvec_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end

            HOLD: begin
                if (wcnt_q != WCNT_LAST) begin
                    wcnt_d = wcnt_q + 1'b1;
                end else begin
                    // Sample edge: y_a/y_b have settled for SETTLE cycles on vec_q.
                    if (y_a != y_b) begin
                        cnt_d = cnt_q + 1'b1;
                        if (!ffv_q) begin
                            ffv_d   = 1'b1;
                            ffvec_d = vec_q;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (cnt_d == '0);
                    end else begin
                        vec_d  = vec_q + 1'b1;
                        wcnt_d = '0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            wcnt_q  <= '0;
            cnt_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign vec_out          = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign mismatch_cnt     = cnt_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_equiv_sweep_checker.sv
// Bench for equiv_sweep_checker: two instances (SETTLE=1 and SETTLE=3) driven from truth tables,
// checked every cycle against a sweep-progress model plus literal expectations per scenario.
module tb_equiv_sweep_checker;

    localparam int N  = 3;
    localparam int NV = 1 << N;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic [NV-1:0] tt_a, tt_b;

    logic [N-1:0] vec_w   [2];
    logic [N:0]   cnt_w   [2];
    logic [N-1:0] ffvec_w [2];
    logic [1:0]   busy_w, done_w, pass_w, ffv_w;

    int n_tests = 0;
    int n_fails = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int S     = (g == 0) ? 1 : 3;
        localparam int TOTAL = NV * S;

        logic y_a_l, y_b_l;
        logic glitch = 1'b0;

        // Model: k = edges since the accepting edge; vectors below k/S have been judged.
        bit            active = 1'b0;
        int            k = 0;
        logic [NV-1:0] diff_snap = '0;

        assign y_a_l = tt_a[vec_w[g]];
        assign y_b_l = tt_b[vec_w[g]] ^ glitch;

        equiv_sweep_checker #(.N(N), .SETTLE(S)) dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .start            (start),
            .vec_out          (vec_w[g]),
            .y_a              (y_a_l),
            .y_b              (y_b_l),
            .busy             (busy_w[g]),
            .done             (done_w[g]),
            .pass             (pass_w[g]),
            .mismatch_cnt     (cnt_w[g]),
            .first_fail_valid (ffv_w[g]),
            .first_fail_vec   (ffvec_w[g])
        );

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                active <= 1'b0;
                k      <= 0;
            end else if (start && !(active && k < TOTAL)) begin
                active    <= 1'b1;
                k         <= 0;
                diff_snap <= tt_a ^ tt_b;
            end else if (active && k < TOTAL) begin
                k <= k + 1;
            end
        end

        // y_b may toggle freely on every edge that is not a sample edge.
        always @(negedge clk) begin
            if (S > 1 && active && k < TOTAL && (k % S) != S - 1)
                glitch <= 1'($urandom);
            else
                glitch <= 1'b0;
        end

        always @(negedge clk) begin : cmp
            int nv, cnt_e, ffvec_e, vec_e;
            bit ffv_e, busy_e, done_e, pass_e;
            cnt_e = 0; ffv_e = 0; ffvec_e = 0; vec_e = 0;
            busy_e = 0; done_e = 0; pass_e = 0;
            if (active) begin
                nv = k / S;
                for (int v = 0; v < NV; v++) begin
                    if (v < nv && diff_snap[v]) begin
                        cnt_e++;
                        if (!ffv_e) begin
                            ffv_e   = 1'b1;
                            ffvec_e = v;
                        end
                    end
                end
                busy_e = (k < TOTAL);
                done_e = (k == TOTAL);
                vec_e  = busy_e ? nv : NV - 1;
                pass_e = done_e && (cnt_e == 0);
            end
            check($sformatf("s%0d_cyc_vec", S),   vec_w[g],   vec_e);
            check($sformatf("s%0d_cyc_busy", S),  busy_w[g],  busy_e);
            check($sformatf("s%0d_cyc_done", S),  done_w[g],  done_e);
            check($sformatf("s%0d_cyc_pass", S),  pass_w[g],  pass_e);
            check($sformatf("s%0d_cyc_cnt", S),   cnt_w[g],   cnt_e);
            check($sformatf("s%0d_cyc_ffv", S),   ffv_w[g],   ffv_e);
            check($sformatf("s%0d_cyc_ffvec", S), ffvec_w[g], ffvec_e);
        end
    end

    function automatic logic [NV-1:0] tt_of(input int which);
        logic [NV-1:0] t;
        logic [N-1:0]  v;
        logic a, b, c;
        t = '0;
        for (int i = 0; i < NV; i++) begin
            v = N'(i);
            a = v[2]; b = v[1]; c = v[0];
            case (which)
                0:       t[i] = ~(a & b) & ((a & b) | (a & c));
                1:       t[i] = a & ~b & c;
                default: t[i] = a & c;
            endcase
        end
        return t;
    endfunction

    // Pulses start, then counts edges until each instance raises done (bounded).
    task automatic sweep(input bit repulse, output int e0, output int e1);
        e0 = -1;
        e1 = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("inst%0d_start_busy", i), busy_w[i], 1);
            check($sformatf("inst%0d_start_done", i), done_w[i], 0);
            check($sformatf("inst%0d_start_pass", i), pass_w[i], 0);
        end
        for (int e = 1; e <= 60 && e1 < 0; e++) begin
            start = repulse && (e == 4);
            @(negedge clk);
            if (done_w[0] && e0 < 0) e0 = e;
            if (done_w[1] && e1 < 0) e1 = e;
        end
        start = 1'b0;
        check("s1_done_edge", e0, NV * 1);
        check("s3_done_edge", e1, NV * 3);
    endtask

    task automatic expect_results(input string tag, input int cnt, input bit ffv,
                                  input int ffvec, input bit ps);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_i%0d_cnt", tag, i),   cnt_w[i],   cnt);
            check($sformatf("%s_i%0d_ffv", tag, i),   ffv_w[i],   ffv);
            check($sformatf("%s_i%0d_ffvec", tag, i), ffvec_w[i], ffvec);
            check($sformatf("%s_i%0d_pass", tag, i),  pass_w[i],  ps);
            check($sformatf("%s_i%0d_vec", tag, i),   vec_w[i],   NV - 1);
        end
    endtask

    task automatic expect_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_i%0d_vec", tag, i),   vec_w[i],   0);
            check($sformatf("%s_i%0d_busy", tag, i),  busy_w[i],  0);
            check($sformatf("%s_i%0d_done", tag, i),  done_w[i],  0);
            check($sformatf("%s_i%0d_pass", tag, i),  pass_w[i],  0);
            check($sformatf("%s_i%0d_cnt", tag, i),   cnt_w[i],   0);
            check($sformatf("%s_i%0d_ffv", tag, i),   ffv_w[i],   0);
            check($sformatf("%s_i%0d_ffvec", tag, i), ffvec_w[i], 0);
        end
    endtask

    initial begin
        int e0, e1;
        rst_n = 1'b0;
        start = 1'b0;
        tt_a  = tt_of(0);
        tt_b  = tt_of(1);
        repeat (3) @(negedge clk);
        expect_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Equivalent pair.
        sweep(1'b0, e0, e1);
        expect_results("equiv", 0, 1'b0, 0, 1'b1);

        // Single fault: only vector 7 differs; restart straight out of DONE.
        tt_b = tt_of(2);
        sweep(1'b0, e0, e1);
        expect_results("fault", 1, 1'b1, 7, 1'b0);

        // Inverted output: every vector differs.
        tt_b = ~tt_a;
        sweep(1'b0, e0, e1);
        expect_results("invert", NV, 1'b1, 0, 1'b0);

        // start re-asserted mid-sweep is ignored.
        tt_b = tt_of(1);
        sweep(1'b1, e0, e1);
        expect_results("repulse", 0, 1'b0, 0, 1'b1);

        // Asynchronous reset between edges in the middle of a sweep.
        tt_b = tt_of(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 expect_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sweep(1'b0, e0, e1);
        expect_results("postrst", 1, 1'b1, 7, 1'b0);

        // Random truth tables, some equal pairs, random mid-sweep start pulses.
        for (int it = 0; it < 8; it++) begin
            tt_a = NV'($urandom);
            tt_b = ($urandom_range(0, 2) == 0) ? tt_a : NV'($urandom);
            sweep(1'($urandom), e0, e1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
